// File: rtl/pci_target_core_if.sv
// PCI target control/handshake lines (active-low). The tristate ad/par pins stay
// on the core as plain inout ports.
interface pci_target_core_if;
    logic [3:0] cbe;
    logic       frame;
    logic       irdy;
    logic       idsel;
    logic       trdy;
    logic       devsel;
    logic       stop;
    logic       inta;
    logic       perr;
    logic       serr;

    modport master (
        output cbe, frame, irdy, idsel,
        input  trdy, devsel, stop, inta, perr, serr
    );

    modport slave (
        input  cbe, frame, irdy, idsel,
        output trdy, devsel, stop, inta, perr, serr
    );
endinterface

// File: rtl/pci_target_core.sv
// 32-bit PCI target: type-0 config header, one memory BAR over a word RAM, bursts,
// byte enables, disconnect and doorbell interrupt. Define PCI_PARITY_EN for parity.
module pci_target_core #(
    parameter int unsigned MEM_WORDS = 256,
    parameter int unsigned MAX_BURST = 16,
    parameter logic [15:0] VENDOR_ID = 16'h10EE,
    parameter logic [15:0] DEVICE_ID = 16'h0001
) (
    input  logic             clk,
    input  logic             rst,
    pci_target_core_if.slave bus,
    inout  wire  [31:0]      ad_io,
    inout  wire              par_io
);
    localparam int unsigned WAW = $clog2(MEM_WORDS);
    localparam int unsigned BAW = WAW + 2;
    localparam int unsigned CW  = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_TURN} state_e;

    state_e            state_q, state_d;
    logic              frame_q;
    logic              trdy_q, trdy_d;
    logic              devsel_q, devsel_d;
    logic              stop_q, stop_d;
    logic              ad_oe_q, ad_oe_d;
    logic [31:0]       ad_out_q, ad_out_d;
    logic              is_read_q, is_read_d;
    logic              is_cfg_q, is_cfg_d;
    logic              rd_wait_q, rd_wait_d;
    logic [WAW-1:0]    addr_q, addr_d;
    logic [5:0]        cfg_reg_q, cfg_reg_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              mem_en_q, mem_en_d;
    logic [31:BAW]     bar_q, bar_d;
    logic [7:0]        int_line_q, int_line_d;
    logic              doorbell_q, doorbell_d;

    logic [31:0]       mem_q [MEM_WORDS];

    logic              cmd_mrd, cmd_mwr, cmd_crd, cmd_cwr;
    logic              addr_edge, cfg_hit, mem_hit;
    logic              xfer, wr_xfer, mem_wr, cfg_wr;
    logic [WAW-1:0]    rd_addr;
    logic [31:0]       cfg_rdata, rdata, bar_wr;
    logic [CW-1:0]     nxt_cnt;

    assign cmd_mrd   = (bus.cbe == 4'b0110) || (bus.cbe == 4'b1100) || (bus.cbe == 4'b1110);
    assign cmd_mwr   = (bus.cbe == 4'b0111);
    assign cmd_crd   = (bus.cbe == 4'b1010);
    assign cmd_cwr   = (bus.cbe == 4'b1011);
    assign addr_edge = !bus.frame && frame_q;
    assign cfg_hit   = bus.idsel && (ad_io[1:0] == 2'b00) && (cmd_crd || cmd_cwr);
    assign mem_hit   = mem_en_q && (ad_io[31:BAW] == bar_q) && (cmd_mrd || cmd_mwr);
    assign xfer      = (state_q == S_DATA) && !bus.irdy && !trdy_q;
    assign wr_xfer   = xfer && !is_read_q;
    assign mem_wr    = wr_xfer && !is_cfg_q;
    assign cfg_wr    = wr_xfer && is_cfg_q;
    assign rd_addr   = rd_wait_q ? addr_q : addr_q + WAW'(1);
    assign rdata     = is_cfg_q ? cfg_rdata : mem_q[rd_addr];
    assign nxt_cnt   = cnt_q + CW'(1);

    // Config space read mux, indexed by dword register number
    always_comb begin
        cfg_rdata = '0;
        case (cfg_reg_q)
            6'h00:   cfg_rdata = {DEVICE_ID, VENDOR_ID};
            6'h01:   cfg_rdata = {30'd0, mem_en_q, 1'b0};
            6'h04:   cfg_rdata = {bar_q, {BAW{1'b0}}};
            6'h0F:   cfg_rdata = {16'h0000, 8'h01, int_line_q};
            6'h10:   cfg_rdata = {31'd0, doorbell_q};
            default: cfg_rdata = '0;
        endcase
    end

    // State register plus all bus-facing and config registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            frame_q    <= 1'b1;
            trdy_q     <= 1'b1;
            devsel_q   <= 1'b1;
            stop_q     <= 1'b1;
            ad_oe_q    <= 1'b0;
            ad_out_q   <= '0;
            is_read_q  <= 1'b0;
            is_cfg_q   <= 1'b0;
            rd_wait_q  <= 1'b0;
            addr_q     <= '0;
            cfg_reg_q  <= '0;
            cnt_q      <= '0;
            mem_en_q   <= 1'b0;
            bar_q      <= '0;
            int_line_q <= '0;
            doorbell_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            frame_q    <= bus.frame;
            trdy_q     <= trdy_d;
            devsel_q   <= devsel_d;
            stop_q     <= stop_d;
            ad_oe_q    <= ad_oe_d;
            ad_out_q   <= ad_out_d;
            is_read_q  <= is_read_d;
            is_cfg_q   <= is_cfg_d;
            rd_wait_q  <= rd_wait_d;
            addr_q     <= addr_d;
            cfg_reg_q  <= cfg_reg_d;
            cnt_q      <= cnt_d;
            mem_en_q   <= mem_en_d;
            bar_q      <= bar_d;
            int_line_q <= int_line_d;
            doorbell_q <= doorbell_d;
        end
    end

    // Next state: any final handshake, idle bus or finished disconnect ends the access
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (addr_edge && (cfg_hit || mem_hit)) state_d = S_DATA;
            S_DATA: if (bus.frame && (xfer || bus.irdy || !stop_q)) state_d = S_TURN;
            S_TURN: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs, data path and config register updates
    always_comb begin
        trdy_d     = trdy_q;
        devsel_d   = devsel_q;
        stop_d     = stop_q;
        ad_oe_d    = ad_oe_q;
        ad_out_d   = ad_out_q;
        is_read_d  = is_read_q;
        is_cfg_d   = is_cfg_q;
        rd_wait_d  = rd_wait_q;
        addr_d     = addr_q;
        cfg_reg_d  = cfg_reg_q;
        cnt_d      = cnt_q;
        mem_en_d   = mem_en_q;
        bar_d      = bar_q;
        int_line_d = int_line_q;
        doorbell_d = doorbell_q;
        bar_wr     = {bar_q, {BAW{1'b0}}};

        case (state_q)
            S_IDLE: begin
                if (addr_edge && (cfg_hit || mem_hit)) begin
                    devsel_d  = 1'b0;
                    is_cfg_d  = cfg_hit;
                    is_read_d = cfg_hit ? cmd_crd : cmd_mrd;
                    rd_wait_d = cfg_hit ? cmd_crd : cmd_mrd;
                    trdy_d    = cfg_hit ? cmd_crd : cmd_mrd;
                    stop_d    = !((cfg_hit ? cmd_cwr : cmd_mwr) && (cfg_hit || MAX_BURST == 1));
                    addr_d    = ad_io[BAW-1:2];
                    cfg_reg_d = ad_io[7:2];
                    cnt_d     = '0;
                end
            end
            S_DATA: begin
                if (state_d == S_TURN) begin
                    trdy_d   = 1'b1;
                    devsel_d = 1'b1;
                    stop_d   = 1'b1;
                    ad_oe_d  = 1'b0;
                end else if (xfer) begin
                    cnt_d  = nxt_cnt;
                    addr_d = addr_q + WAW'(1);
                    // After the disconnecting phase no more data is offered
                    if (!stop_q) begin
                        trdy_d  = 1'b1;
                        ad_oe_d = 1'b0;
                    end else begin
                        if (is_read_q) ad_out_d = rdata;
                        if (nxt_cnt == CW'(MAX_BURST - 1)) stop_d = 1'b0;
                    end
                end else if (rd_wait_q) begin
                    rd_wait_d = 1'b0;
                    trdy_d    = 1'b0;
                    ad_oe_d   = 1'b1;
                    ad_out_d  = rdata;
                    if (is_cfg_q || MAX_BURST == 1) stop_d = 1'b0;
                end
            end
            default: rd_wait_d = 1'b0;
        endcase

        if (cfg_wr) begin
            case (cfg_reg_q)
                6'h01: if (!bus.cbe[0]) mem_en_d = ad_io[1];
                6'h04: begin
                    for (int b = 0; b < 4; b++) begin
                        if (!bus.cbe[b]) bar_wr[8*b +: 8] = ad_io[8*b +: 8];
                    end
                    bar_d = bar_wr[31:BAW];
                end
                6'h0F: if (!bus.cbe[0]) int_line_d = ad_io[7:0];
                6'h10: if (!bus.cbe[0] && ad_io[0]) doorbell_d = 1'b0;
                default: ;
            endcase
        end
        // Setting the doorbell has priority over a same-cycle clear
        if (mem_wr && (addr_q == {WAW{1'b1}})) doorbell_d = 1'b1;
    end

    // Word RAM with byte-enable writes; contents survive reset
    always_ff @(posedge clk) begin
        if (!rst && mem_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (!bus.cbe[b]) mem_q[addr_q][8*b +: 8] <= ad_io[8*b +: 8];
            end
        end
    end

    assign ad_io      = ad_oe_q ? ad_out_q : 32'bz;
    assign bus.trdy   = trdy_q;
    assign bus.devsel = devsel_q;
    assign bus.stop   = stop_q;
    assign bus.inta   = ~doorbell_q;
    assign bus.serr   = 1'b1;

`ifdef PCI_PARITY_EN
    logic par_q, par_oe_q, perr_q, wpar_pend_q, wpar_q;

    // Read parity follows each driven ad cycle; write parity is checked one cycle late
    always_ff @(posedge clk) begin
        if (rst) begin
            par_q       <= 1'b0;
            par_oe_q    <= 1'b0;
            perr_q      <= 1'b1;
            wpar_pend_q <= 1'b0;
            wpar_q      <= 1'b0;
        end else begin
            par_q       <= ^{ad_out_q, bus.cbe};
            par_oe_q    <= ad_oe_q;
            wpar_pend_q <= wr_xfer;
            wpar_q      <= ^{ad_io, bus.cbe};
            perr_q      <= !(wpar_pend_q && (par_io != wpar_q));
        end
    end

    assign par_io   = par_oe_q ? par_q : 1'bz;
    assign bus.perr = perr_q;
`else
    assign par_io   = 1'bz;
    assign bus.perr = 1'b1;
`endif

endmodule
